shift_engine: RTL and testbench

//  Framed serialiser/deserialiser, the successor of the fixed-direction shift register. Parametrised in WIDTH.

---
 rtl/shift_engine_pkg.sv | 8 +
 rtl/shift_core.sv | 41 ++++
 rtl/shift_engine.sv | 117 +++++++++++
 tb/tb_shift_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// Shared types for the framed serialiser/deserialiser.
package shift_engine_pkg;

  typedef enum logic {SE_IDLE, SE_RUN} se_state_t;

  typedef enum logic {SE_PISO = 1'b0, SE_SIPO = 1'b1} se_mode_t;

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit shift register with parallel load and run-time shift direction.
module shift_core
  import shift_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             msb_first,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             tap_msb,
  output logic             tap_lsb
);

  logic [WIDTH-1:0] reg_q, reg_d;

  // Load wins over shift so a start coinciding with a strobe is not counted.
  always_comb begin
    reg_d = reg_q;
    if (load) begin
      reg_d = load_val;
    end else if (shift_en) begin
      if (msb_first) reg_d = {reg_q[WIDTH-2:0], sin};
      else           reg_d = {sin, reg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) reg_q <= '0;
    else     reg_q <= reg_d;
  end

  assign q       = reg_q;
  assign tap_msb = reg_q[WIDTH-1];
  assign tap_lsb = reg_q[0];

endmodule

// File: rtl/shift_engine.sv
// Framed PISO/SIPO engine: run-time direction and mode, baud-strobe gated,
// bit counting and a one-cycle done pulse after the last shift.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic                       msb_first,
  input  logic [WIDTH-1:0]           data_in_p,
  input  logic                       data_in_s,
  input  logic                       shift,
  input  logic                       abort,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           data_out_p,
  output logic                       data_out_s,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int unsigned          CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        LAST_CNT = CW'(WIDTH - 1);

  se_state_t        state_q, state_d;
  se_mode_t         mode_q, mode_d;
  logic             msb_q, msb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic             core_shift;
  logic             core_dir;
  logic             tap_msb, tap_lsb;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    msb_d         = msb_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    core_load     = 1'b0;
    core_load_val = '0;
    core_shift    = 1'b0;
    core_dir      = msb_q;
    unique case (state_q)
      SE_IDLE: begin
        if (start) begin
          state_d       = SE_RUN;
          mode_d        = se_mode_t'(mode);
          msb_d         = msb_first;
          cnt_d         = '0;
          core_load     = 1'b1;
          core_load_val = (se_mode_t'(mode) == SE_PISO) ? data_in_p : '0;
        end
      end
      SE_RUN: begin
        // Abort clears through the load path and overrides any strobe.
        if (abort) begin
          state_d   = SE_IDLE;
          cnt_d     = '0;
          core_load = 1'b1;
        end else if (shift) begin
          core_shift = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = SE_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = SE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SE_IDLE;
      mode_q  <= SE_PISO;
      msb_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      msb_q   <= msb_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .load_val  (core_load_val),
    .shift_en  (core_shift),
    .msb_first (core_dir),
    .sin       (data_in_s),
    .q         (data_out_p),
    .tap_msb   (tap_msb),
    .tap_lsb   (tap_lsb)
  );

  assign busy       = (state_q == SE_RUN);
  assign ready      = ~busy;
  assign done       = done_q;
  assign bit_cnt    = cnt_q;
  assign data_out_s = (state_q == SE_RUN && mode_q == SE_PISO)
                      ? (msb_q ? tap_msb : tap_lsb) : IDLE_LEVEL;

endmodule

// File: tb/tb_shift_engine.sv
// Directed plus randomized frames for shift_engine (WIDTH=8, IDLE_LEVEL=1),
// checked against a bit-sequence model of the framing rules.
module tb_shift_engine;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, start, mode, msb_first, data_in_s, shift, abort;
  logic [7:0] data_in_p;
  logic       ready, busy, done, data_out_s;
  logic [7:0] data_out_p;
  logic [3:0] bit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  shift_engine #(.WIDTH(8), .IDLE_LEVEL(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .msb_first  (msb_first),
    .data_in_p  (data_in_p),
    .data_in_s  (data_in_s),
    .shift      (shift),
    .abort      (abort),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .data_out_p (data_out_p),
    .data_out_s (data_out_s),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word formed by a serial bit sequence entering the register in the given order.
  function automatic logic [7:0] assemble(input logic msb, input logic [7:0] ser);
    logic [7:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (msb) w[W-1-k] = ser[k];
      else     w[k]     = ser[k];
    end
    return w;
  endfunction

  // Bit k of the transmitted sequence for a PISO word.
  function automatic logic tx_bit(input logic msb, input logic [7:0] word, input int k);
    return msb ? word[W-1-k] : word[k];
  endfunction

  task automatic chk_idle_reset(input string tag);
    chk({tag, ".ready"}, ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".cnt"}, bit_cnt, 0);
    chk({tag, ".pout"}, data_out_p, 0);
    chk({tag, ".sout"}, data_out_s, 1);
  endtask

  // Runs one frame from an idle/done cycle. abort_at/rst_at >= 0 interrupt
  // the frame before that shift; otherwise it returns in the done cycle.
  task automatic do_frame(input string tag, input logic md, input logic msb,
                          input logic [7:0] word, input logic [7:0] ser,
                          input int abort_at, input int rst_at,
                          input logic start_shift, input logic noise);
    logic exp_s;
    start = 1; mode = md; msb_first = msb; data_in_p = word;
    shift = start_shift; data_in_s = $urandom_range(0, 1);
    tick();
    start = 0; shift = 0;
    chk({tag, ".busy0"}, busy, 1);
    chk({tag, ".ready0"}, ready, 0);
    chk({tag, ".cnt0"}, bit_cnt, 0);
    chk({tag, ".load"}, data_out_p, md ? 8'h00 : word);
    for (int k = 0; k < W; k++) begin
      exp_s = md ? 1'b1 : tx_bit(msb, word, k);
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          start = $urandom_range(0, 1); data_in_p = 8'($urandom);
          data_in_s = $urandom_range(0, 1);
          tick();
          start = 0;
          chk({tag, ".gapcnt"}, bit_cnt, k);
          chk({tag, ".gapbusy"}, busy, 1);
        end
      end
      chk({tag, ".sout"}, data_out_s, exp_s);
      if (k == abort_at) begin
        abort = 1; shift = $urandom_range(0, 1);
        tick();
        abort = 0; shift = 0;
        chk_idle_reset({tag, ".abort"});
        tick();
        chk({tag, ".abort.nodone"}, done, 0);
        return;
      end
      if (k == rst_at) begin
        rst = 1; shift = 1;
        tick();
        rst = 0; shift = 0;
        chk_idle_reset({tag, ".rst"});
        tick();
        chk({tag, ".rst.nodone"}, done, 0);
        return;
      end
      shift = 1; data_in_s = ser[k];
      tick();
      shift = 0;
      chk({tag, ".cnt"}, bit_cnt, k + 1);
      chk({tag, ".done"}, done, k == W - 1);
      chk({tag, ".busy"}, busy, k != W - 1);
    end
    chk({tag, ".ready"}, ready, 1);
    chk({tag, ".idle_s"}, data_out_s, 1);
    chk({tag, ".pout"}, data_out_p, assemble(msb, ser));
  endtask

  initial begin
    logic [7:0] w, s, held;
    logic       md, msb;

    rst = 1; start = 0; mode = 0; msb_first = 0; data_in_p = '0;
    data_in_s = 0; shift = 0; abort = 0;
    tick(); tick();
    rst = 0;
    chk_idle_reset("reset");

    do_frame("piso_a5", 1'b0, 1'b1, 8'hA5, 8'h00, -1, -1, 1'b0, 1'b0);
    tick();
    chk("hold.done", done, 0);
    chk("hold.cnt", bit_cnt, 8);

    // Serial 1,0,1,1,0,0,1,0 LSB first, as bit k of ser.
    do_frame("sipo_4d", 1'b1, 1'b0, 8'h00, 8'b0100_1101, -1, -1, 1'b0, 1'b1);
    chk("sipo_4d.word", data_out_p, 8'h4D);
    held = data_out_p;
    tick();
    abort = 1; shift = 1;
    tick();
    abort = 0; shift = 0;
    chk("idle_abort.cnt", bit_cnt, 8);
    chk("idle_abort.word", data_out_p, held);
    chk("idle_abort.ready", ready, 1);

    do_frame("abort_ff", 1'b0, 1'b1, 8'hFF, 8'hFF, 3, -1, 1'b0, 1'b0);

    // Mid-frame start pulses are injected by the noise gaps; 8'hC3 follows in the done cycle.
    do_frame("b2b_3c", 1'b0, 1'b1, 8'h3C, 8'h5A, -1, -1, 1'b0, 1'b1);
    do_frame("b2b_c3", 1'b0, 1'b1, 8'hC3, 8'hA5, -1, -1, 1'b0, 1'b0);

    do_frame("rst_mid", 1'b1, 1'b1, 8'h00, 8'h96, -1, 5, 1'b0, 1'b0);

    repeat (3) begin
      shift = 1; data_in_s = $urandom_range(0, 1);
      tick();
    end
    shift = 0;
    chk("idle_shift.cnt", bit_cnt, 0);
    chk("idle_shift.busy", busy, 0);
    do_frame("start_shift", 1'b0, 1'b0, 8'h96, 8'h3C, -1, -1, 1'b1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      md  = $urandom_range(0, 1);
      msb = $urandom_range(0, 1);
      w   = 8'($urandom);
      s   = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       do_frame("rnd_abort", md, msb, w, s, $urandom_range(0, 7), -1, 1'b0, 1'b1);
        1:       do_frame("rnd_rst", md, msb, w, s, -1, $urandom_range(0, 7), 1'b0, 1'b1);
        default: do_frame("rnd", md, msb, w, s, -1, -1, $urandom_range(0, 1), 1'b1);
      endcase
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
